// File: rtl/wyswietl_pkg.sv
// wyswietl_pkg: segment/anode constants and scan FSM states shared by the display driver and reader.
package wyswietl_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [7:0] AN_HR2   = 8'b11110111;
  localparam logic [7:0] AN_HR1   = 8'b11111011;
  localparam logic [7:0] AN_MIN2  = 8'b11111101;
  localparam logic [7:0] AN_MIN1  = 8'b11111110;
  localparam logic [7:0] AN_BLANK = 8'b11111111;
  typedef enum logic [1:0] {SZUKAJ, H1, M2, M1} stan_t;
endpackage

// File: rtl/wyswietl_odczyt_seg_dekoder.sv
// seg_dekoder: active-low 7-segment pattern (bit 6 = a) back to BCD with a valid flag.
module seg_dekoder
  import wyswietl_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] val_o,
  output logic       valid_o
);
  always_comb begin
    val_o   = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   val_o = 4'd0;
      SEG_1:   val_o = 4'd1;
      SEG_2:   val_o = 4'd2;
      SEG_3:   val_o = 4'd3;
      SEG_4:   val_o = 4'd4;
      SEG_5:   val_o = 4'd5;
      SEG_6:   val_o = 4'd6;
      SEG_7:   val_o = 4'd7;
      SEG_8:   val_o = 4'd8;
      SEG_9:   val_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/wyswietl_odczyt.sv
// wyswietl_odczyt: reads back a multiplexed HH:MM seven-segment bus and commits whole, range-checked frames.
// Optional BLAD_LICZNIK_EN adds blad_cnt_o, a saturating discard counter.
module wyswietl_odczyt
  import wyswietl_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] an_i,
  input  logic [7:0] seg_i,
  output logic [1:0] hr2_o,
  output logic [3:0] hr1_o,
  output logic [3:0] min2_o,
  output logic [3:0] min1_o,
  output logic       kropka_o,
  output logic       ramka_o,
  output logic       blad_o,
  output logic       sync_o
`ifdef BLAD_LICZNIK_EN
  ,
  output logic [7:0] blad_cnt_o
`endif
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [7:0] an_q, seg_q, an_p, seg_p, exp_an;
  logic [SW-1:0] st_cnt;
  logic [TW-1:0] t_cnt;
  logic [3:0] val, sh_hr2, sh_hr1, sh_min2;
  logic valid, same, acc, ok, start, zakres, commit, discard;
  stan_t stan_q, stan_d;
  seg_dekoder u_dek (.seg_i(seg_q[6:0]), .val_o(val), .valid_o(valid));
  // acc fires only on the cycle the counter steps onto STABLE_CYCLES, so a held dwell is taken once
  always_comb begin
    same    = {an_q, seg_q} == {an_p, seg_p};
    acc     = same && an_q != AN_BLANK && st_cnt == SW'(STABLE_CYCLES - 1);
    exp_an  = stan_q == SZUKAJ ? AN_HR2 : stan_q == H1 ? AN_HR1 : stan_q == M2 ? AN_MIN2 : AN_MIN1;
    ok      = acc && valid && an_q == exp_an;
    start   = acc && valid && an_q == AN_HR2;
    zakres  = sh_hr2 <= 4'd2 && !(sh_hr2 == 4'd2 && sh_hr1 > 4'd3) && sh_min2 <= 4'd5;
    commit  = ok && stan_q == M1 && zakres;
    discard = acc && !(ok && (stan_q != M1 || zakres));
    stan_d  = discard ? (start ? H1 : SZUKAJ) :
              !ok ? stan_q :
              stan_q == SZUKAJ ? H1 : stan_q == H1 ? M2 : stan_q == M2 ? M1 : SZUKAJ;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stan_q <= SZUKAJ;
    else stan_q <= stan_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q   <= AN_BLANK;
      seg_q  <= '0;
      an_p   <= AN_BLANK;
      seg_p  <= '0;
      st_cnt <= '0;
    end else begin
      an_q   <= an_i;
      seg_q  <= seg_i;
      an_p   <= an_q;
      seg_p  <= seg_q;
      st_cnt <= (an_q == AN_BLANK || !same) ? '0 :
                st_cnt == SW'(STABLE_CYCLES) ? st_cnt : st_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_hr2  <= '0;
      sh_hr1  <= '0;
      sh_min2 <= '0;
    end else begin
      sh_hr2  <= discard ? (start ? val : 4'd0) : (ok && stan_q == SZUKAJ) ? val : sh_hr2;
      sh_hr1  <= discard ? 4'd0 : (ok && stan_q == H1) ? val : sh_hr1;
      sh_min2 <= discard ? 4'd0 : (ok && stan_q == M2) ? val : sh_min2;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hr2_o    <= '0;
      hr1_o    <= '0;
      min2_o   <= '0;
      min1_o   <= '0;
      kropka_o <= 1'b0;
      ramka_o  <= 1'b0;
      blad_o   <= 1'b0;
      sync_o   <= 1'b0;
      t_cnt    <= '0;
    end else begin
      hr2_o    <= commit ? sh_hr2[1:0] : hr2_o;
      hr1_o    <= commit ? sh_hr1 : hr1_o;
      min2_o   <= commit ? sh_min2 : min2_o;
      min1_o   <= commit ? val : min1_o;
      kropka_o <= commit ? seg_q[7] : kropka_o;
      ramka_o  <= commit;
      blad_o   <= discard;
      t_cnt    <= commit ? '0 : t_cnt == TW'(TIMEOUT) ? t_cnt : t_cnt + 1'b1;
      sync_o   <= commit ? 1'b1 : t_cnt == TW'(TIMEOUT - 1) ? 1'b0 : sync_o;
    end
  end
`ifdef BLAD_LICZNIK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) blad_cnt_o <= '0;
    else blad_cnt_o <= (discard && blad_cnt_o != 8'hFF) ? blad_cnt_o + 1'b1 : blad_cnt_o;
  end
`endif
endmodule

// File: doc/wyswietl_odczyt.md
Name: wyswietl_odczyt

Overview:
Receiver for the multiplexed 4-digit HH:MM seven-segment bus that the display driver produces (active-low anodes, active-low segments, dot on seg bit 7). The block samples the anode/segment lines, tracks the scan order, and decodes segment patterns back to BCD. It range-checks each frame and commits a complete, valid time atomically. It is used as a remote display mirror and as a self-check monitor on the board-level display bus.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (min 2).
TIMEOUT, 100000, cycles without a committed frame before sync_o drops.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
an_i  in  8  anode lines, active-low; only bits 3:0 used (3 = hr2, 2 = hr1, 1 = min2, 0 = min1).
seg_i  in  8  segment lines, active-low; bits 6:0 = a..g (bit 6 = a), bit 7 = dot.
hr2_o  out  2  decoded tens of hours.
hr1_o  out  4  decoded units of hours.
min2_o  out  4  decoded tens of minutes.
min1_o  out  4  decoded units of minutes.
kropka_o  out  1  dot state captured with min1 (raw seg_i[7]).
ramka_o  out  1  one-cycle pulse when a frame is committed.
blad_o  out  1  one-cycle pulse on any frame discard.
sync_o  out  1  high while frames commit within TIMEOUT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values: all digit outputs 0, kropka_o 0, ramka_o 0, blad_o 0, sync_o 0; FSM in SZUKAJ; shadow registers, stability counter and timeout counter cleared.
- Input stage: an_i and seg_i are registered once. The stability counter increments while the registered sample equals the previous one, saturating at STABLE_CYCLES. Any change resets it to 0.
- Acceptance: a digit is accepted in the single cycle the counter first reaches STABLE_CYCLES. A repeat of the same dwell is never re-accepted.
- Blank: an = 8'hFF resets the counter only; no state change and no error.
- Decode table (seg bits 6:0 to value): 0000001 = 0, 1001111 = 1, 0010010 = 2, 0000110 = 3, 1001100 = 4, 0100100 = 5, 0100000 = 6, 0001111 = 7, 0000000 = 8, 0000100 = 9. Any other pattern is invalid.
- FSM states:
  - SZUKAJ: waits for an accepted an = 11110111, then goes to H1.
  - H1: expects 11111011, then goes to M2.
  - M2: expects 11111101, then goes to M1.
  - M1: expects 11111110, then commits and returns to SZUKAJ.
  - In every state, the accepted digit is stored in the shadow register for that position.
- Discard: an accepted sample with the wrong anode, more than one anode low, or an invalid pattern causes discard. On discard: blad_o pulses, shadow registers are cleared, FSM returns to SZUKAJ. If the offending sample is itself an = 11110111 with a valid pattern, it is taken as a new start (FSM goes to H1).
- Range check at commit: hr2 ≤ 2; hr1 ≤ 9, and hr1 ≤ 3 when hr2 = 2; min2 ≤ 5; min1 ≤ 9. A failure is a discard; outputs hold their previous values.
- Commit: outputs update and ramka_o pulses on the clock edge after M1 acceptance, giving 2-cycle latency from the M1 sample edge through the input flop. All four digits update in the same cycle.
- Timeout: the counter clears on commit and otherwise increments, saturating. sync_o is set on commit and cleared when the count reaches TIMEOUT. Digit outputs hold their values through a timeout.
- Simultaneous events: a commit clears the timeout count in the same cycle the count would reach TIMEOUT, so sync_o stays 1.
- Reset mid-frame: shadow registers and FSM clear immediately.

Optional Feature:
BLAD_LICZNIK_EN.
- Defined: adds output port blad_cnt_o [7:0], a saturating count of discards (stops at 255), cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package wyswietl_pkg holds:
  - the segment pattern constants SEG_0..SEG_9;
  - the anode constants AN_HR2, AN_HR1, AN_MIN2, AN_MIN1;
  - the FSM state enum (SZUKAJ, H1, M2, M1).
- The display driver is to use the same constants.
- One sub-module: seg_dekoder, combinational, 7-bit pattern in, 4-bit value and valid flag out.

Test Plan:
- Valid frame: scan 1, 2, 3, 4 (patterns 1001111, 0010010, 0000110, 1001100) in order hr2, hr1, min2, min1, dot = 0, dwell 8 cycles each -> hr2_o = 1, hr1_o = 2, min2_o = 3, min1_o = 4, one ramka_o pulse 2 cycles after the M1 sample, sync_o = 1.
- Glitch: 2-cycle wrong-pattern glitch inside a valid dwell with STABLE_CYCLES = 4 -> no blad_o pulse, frame still commits.
- Order error: after hr2 = 1, feed anode 1 (min2) -> blad_o pulse, FSM in SZUKAJ, outputs unchanged.
- Range error: full frame 2, 5, 0, 0 -> blad_o pulse, no ramka_o pulse, previous time held. Full frame 2, 3, 5, 9 -> commits 23:59.
- Invalid pattern 1111111 on hr1 -> discard; a following valid frame commits normally.
- Timeout: stop scanning after a commit -> sync_o falls exactly TIMEOUT cycles after ramka_o while digits hold. Assert rst_ni mid-frame -> all outputs 0 asynchronously. With BLAD_LICZNIK_EN, 3 discards -> blad_cnt_o = 3.
